spi_controller: RTL and testbench

- Controller (initiator) end of the team's SPI memory link; drives `sclk`, `cs` and `mosi`, and samples `miso`.
- Issues one framed transaction per `start`: 7-bit address, R/W bit, turnaround clocks, then 8 data bits.
- Writes send `wdata`; reads capture the peripheral's byte into `rdata`.
- Sits between a host-side command interface and the off-block SPI peripheral memory.

---
 rtl/spi_controller_pkg.sv | 27 ++
 rtl/spi_controller_sclk_gen.sv | 60 ++++++
 rtl/spi_controller.sv | 210 +++++++++++++++++++++
 tb/tb_spi_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_controller_pkg.sv
// Shared definitions for the SPI memory-link controller: FSM state encoding,
// transfer direction constants and default frame geometry.
`timescale 1ns/1ps
package spi_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LAST  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_ADDR_W    = 7;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_TA_CYCLES = 2;

    // Number of sclk rising edges in one frame: address, R/W, turnaround, data.
    function automatic int frame_len(input int aw, input int dw, input int ta);
        return aw + 1 + ta + dw;
    endfunction

endpackage

// File: rtl/spi_controller_sclk_gen.sv
// Half-period timebase for the SPI controller. Produces a tick every CLK_DIV
// clk cycles while enabled, and a registered sclk that toggles on ticks when
// the FSM allows it. rise/fall flag the tick that will move sclk up/down.
`timescale 1ns/1ps
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    input  logic toggle_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign tick = enable && (cnt_q == CW'(CLK_DIV - 1));
    assign rise = tick && toggle_en && !sclk_q;
    assign fall = tick && toggle_en && sclk_q;
    assign sclk = sclk_q;

    // Next half-period count and sclk level; idle or restart parks both at zero.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!enable || restart) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick) begin
            cnt_d  = '0;
            if (toggle_en) begin
                sclk_d = ~sclk_q;
            end else begin
                sclk_d = sclk_q;
            end
        end else begin
            cnt_d  = cnt_q + CW'(1);
            sclk_d = sclk_q;
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller for the memory link. One start issues one frame:
// address (MSB first), R/W, turnaround zeros, then a data byte. Reads capture
// miso on data rising edges and publish the byte on rdata with done.
`timescale 1ns/1ps
module spi_controller
    import spi_defs::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TA_CYCLES = DEF_TA_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int N          = frame_len(ADDR_W, DATA_W, TA_CYCLES);
    localparam int EW         = $clog2(N + 1);
    localparam int FIRST_DATA = N - DATA_W;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              rw_q, rw_d;
    logic              hold2_q, hold2_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [N-1:0]      shift_q, shift_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic [N-1:0]      frame_s;

    logic tick, rise, fall, gen_restart, toggle_en;

    assign gen_restart = (state_q == ST_IDLE) && start;
    assign toggle_en   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_LAST);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .enable    (busy_q),
        .restart   (gen_restart),
        .toggle_en (toggle_en),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall),
        .sclk      (sclk)
    );

    // Assemble the outgoing frame from the request inputs; reads send zero data.
    always_comb begin
        frame_s                    = '0;
        frame_s[N-1 -: ADDR_W]     = addr;
        frame_s[DATA_W + TA_CYCLES] = rw;
        if (rw == WRITE) begin
            frame_s[DATA_W-1:0] = wdata;
        end else begin
            frame_s[DATA_W-1:0] = '0;
        end
    end

    // Frame sequencing: next state, serial output, edge counting and capture.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        rw_d    = rw_q;
        hold2_d = hold2_q;
        rdata_d = rdata_q;
        shift_d = shift_q;
        edge_d  = edge_q;

        if (rise && (rw_q == READ) && (edge_q >= EW'(FIRST_DATA))) begin
            cap_d = {cap_q[DATA_W-2:0], miso};
        end else begin
            cap_d = cap_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    mosi_d  = frame_s[N-1];
                    shift_d = {frame_s[N-2:0], 1'b0};
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    edge_d  = '0;
                    hold2_d = 1'b0;
                    cap_d   = '0;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (rise) begin
                    edge_d  = edge_q + EW'(1);
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (fall) begin
                    if (edge_q < EW'(N)) begin
                        mosi_d  = shift_q[N-1];
                        shift_d = {shift_q[N-2:0], 1'b0};
                    end else begin
                        mosi_d  = mosi_q;
                    end
                end else if (rise) begin
                    edge_d = edge_q + EW'(1);
                    if (edge_q == EW'(N - 1)) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_LAST: begin
                if (fall) begin
                    mosi_d  = 1'b0;
                    hold2_d = 1'b0;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_LAST;
                end
            end
            ST_HOLD: begin
                // sclk stays low for two half-periods before cs is released.
                if (tick && !hold2_q) begin
                    hold2_d = 1'b1;
                end else if (tick) begin
                    hold2_d = 1'b0;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    edge_d  = '0;
                    state_d = ST_IDLE;
                    if (rw_q == READ) begin
                        rdata_d = cap_q;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_d    = 1'b1;
                busy_d  = 1'b0;
                mosi_d  = 1'b0;
                edge_d  = '0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            rw_q    <= 1'b0;
            hold2_q <= 1'b0;
            rdata_q <= '0;
            cap_q   <= '0;
            shift_q <= '0;
            edge_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            rw_q    <= rw_d;
            hold2_q <= hold2_d;
            rdata_q <= rdata_d;
            cap_q   <= cap_d;
            shift_q <= shift_d;
            edge_q  <= edge_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: instance A uses defaults (N=18,
// CLK_DIV=4), instance B uses CLK_DIV=2, TA_CYCLES=0 (N=16). Requests push
// an expected frame record; a negedge monitor reconstructs each frame from the
// pins, plays the peripheral on miso, and pops/compares at every cs release.
`timescale 1ns/1ps
module tb_spi_controller;

    typedef struct {
        logic [31:0] frame;
        int          n;
        logic        rw;
        logic [7:0]  pbyte;
        logic [7:0]  rexp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, rw_a = 1'b0, miso_a = 1'b0;
    logic start_b = 1'b0, rw_b = 1'b0, miso_b = 1'b0;
    logic [6:0] addr_a = 7'd0, addr_b = 7'd0;
    logic [7:0] wdata_a = 8'd0, wdata_b = 8'd0;
    logic busy_a, done_a, sclk_a, cs_a, mosi_a;
    logic busy_b, done_b, sclk_b, cs_b, mosi_b;
    logic [7:0] rdata_a, rdata_b;

    int checks = 0;
    int failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0]  model_rd [2];
    int          cdiv [2] = '{4, 2};
    int          tacyc [2] = '{2, 0};
    int          cs_low_cnt [2], phase_cnt [2], rises [2], high_cnt [2];
    int          last_gap [2], done_cnt [2];
    logic        prev_cs [2], prev_sclk [2];
    logic [31:0] bits [2];

    spi_controller dut_a (
        .clk(clk), .reset(reset), .start(start_a), .rw(rw_a), .addr(addr_a),
        .wdata(wdata_a), .busy(busy_a), .done(done_a), .rdata(rdata_a),
        .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_controller #(.CLK_DIV(2), .TA_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .rw(rw_b), .addr(addr_b),
        .wdata(wdata_b), .busy(busy_b), .done(done_b), .rdata(rdata_b),
        .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference record for one request: frame bits from the field layout,
    // and the rdata value the link must show after this frame.
    task automatic make_exp(input int i, input logic r, input logic [6:0] ad,
                            input logic [7:0] wd, input logic [7:0] pb, output exp_t e);
        longint f;
        f = ad;
        f = f * 2 + r;
        f = f << tacyc[i];
        f = f * 256 + (r ? 0 : wd);
        e.frame = f[31:0];
        e.n     = 7 + 1 + tacyc[i] + 8;
        e.rw    = r;
        e.pbyte = pb;
        if (r) model_rd[i] = pb;
        e.rexp  = model_rd[i];
    endtask

    task automatic issue(input int i, input logic r, input logic [6:0] ad,
                         input logic [7:0] wd, input logic [7:0] pb);
        exp_t e;
        make_exp(i, r, ad, wd, pb, e);
        if (i == 0) begin
            start_a = 1'b1; rw_a = r; addr_a = ad; wdata_a = wd; q_a.push_back(e);
        end else begin
            start_b = 1'b1; rw_b = r; addr_b = ad; wdata_b = wd; q_b.push_back(e);
        end
        @(negedge clk);
        if (i == 0) begin
            start_a = 1'b0; rw_a = 1'($urandom); addr_a = 7'($urandom); wdata_a = 8'($urandom);
        end else begin
            start_b = 1'b0; rw_b = 1'($urandom); addr_b = 7'($urandom); wdata_b = 8'($urandom);
        end
    endtask

    task automatic wait_done(input int i, input int budget);
        int k;
        k = 0;
        while (!((i == 0) ? done_a : done_b) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // Pin-level monitor and peripheral model for one instance.
    task automatic mon(input int i, input logic cs, input logic sclk, input logic mosi,
                       input logic done, input logic [7:0] rdata, output logic miso);
        exp_t h;
        bit   have;
        bit   rose;
        int   e;
        have = 0;
        miso = 1'b0;
        if (i == 0) begin
            if (q_a.size() > 0) begin have = 1; h = q_a[0]; end
        end else begin
            if (q_b.size() > 0) begin have = 1; h = q_b[0]; end
        end
        rose = (prev_cs[i] == 1'b0) && (cs == 1'b1);
        if (done || rose) chk("done_with_cs_release", 32'(done), 32'(rose));
        if (cs == 1'b0) begin
            if (prev_cs[i] == 1'b1) begin
                last_gap[i] = high_cnt[i];
                cs_low_cnt[i] = 0; phase_cnt[i] = 1; rises[i] = 0; bits[i] = 32'd0;
            end else if (sclk != prev_sclk[i]) begin
                chk("sclk_phase_len", 32'(phase_cnt[i]), 32'(cdiv[i]));
                phase_cnt[i] = 1;
                if (sclk) begin
                    rises[i]++;
                    bits[i] = (bits[i] << 1) | 32'(mosi);
                end
            end else begin
                phase_cnt[i]++;
            end
            cs_low_cnt[i]++;
            if (!sclk && have && h.rw) begin
                e = rises[i] + 1;
                if (e > h.n - 8 && e <= h.n) miso = h.pbyte[h.n - e];
            end
        end else begin
            chk("idle_sclk_low", 32'(sclk), 32'd0);
            if (rose) begin
                done_cnt[i]++;
                high_cnt[i] = 1;
                if (!have) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    chk("rising_edges", 32'(rises[i]), 32'(h.n));
                    chk("mosi_frame", bits[i], h.frame);
                    chk("cs_low_cycles", 32'(cs_low_cnt[i]), 32'((2 * h.n + 2) * cdiv[i]));
                    chk("rdata", 32'(rdata), 32'(h.rexp));
                    if (i == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
                end
            end else begin
                high_cnt[i]++;
            end
        end
        prev_cs[i]   = cs;
        prev_sclk[i] = sclk;
    endtask

    // Sample pins away from the active edge and drive miso for the next rise.
    always @(negedge clk) begin
        logic m;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; high_cnt[i] = 0;
                cs_low_cnt[i] = 0; rises[i] = 0; phase_cnt[i] = 0;
            end
            miso_a = 1'b0;
            miso_b = 1'b0;
        end else begin
            mon(0, cs_a, sclk_a, mosi_a, done_a, rdata_a, m);
            miso_a = m;
            mon(1, cs_b, sclk_b, mosi_b, done_b, rdata_b, m);
            miso_b = m;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, k;
        model_rd[0] = 8'd0;
        model_rd[1] = 8'd0;
        for (int i = 0; i < 2; i++) begin done_cnt[i] = 0; last_gap[i] = 0; end

        repeat (3) @(negedge clk);
        chk("reset_cs", 32'(cs_a), 32'd1);
        chk("reset_sclk", 32'(sclk_a), 32'd0);
        chk("reset_mosi", 32'(mosi_a), 32'd0);
        chk("reset_busy", 32'(busy_a), 32'd0);
        chk("reset_done", 32'(done_a), 32'd0);
        chk("reset_rdata", 32'(rdata_a), 32'd0);
        chk("reset_cs_b", 32'(cs_b), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Directed write, then directed read.
        issue(0, 1'b0, 7'h2A, 8'hC3, 8'h00);
        chk("busy_after_start", 32'(busy_a), 32'd1);
        wait_done(0, 400);
        chk("write_keeps_rdata", 32'(rdata_a), 32'd0);
        issue(0, 1'b1, 7'h05, 8'h77, 8'h9E);
        wait_done(0, 400);
        chk("read_rdata_9e", 32'(rdata_a), 32'h9E);

        // Back-to-back: start held across done, extra pulses while busy ignored.
        d0 = done_cnt[0];
        issue(0, 1'b0, 7'h11, 8'h5A, 8'h00);
        begin
            exp_t e2;
            make_exp(0, 1'b1, 7'h33, 8'h00, 8'hA5, e2);
            start_a = 1'b1; rw_a = 1'b1; addr_a = 7'h33; wdata_a = 8'h00;
            q_a.push_back(e2);
        end
        wait_done(0, 400);
        start_a = 1'b0;
        for (int p = 0; p < 3; p++) begin
            repeat (20) @(negedge clk);
            start_a = 1'b1; rw_a = 1'($urandom); addr_a = 7'($urandom); wdata_a = 8'($urandom);
            @(negedge clk);
            start_a = 1'b0;
        end
        wait_done(0, 400);
        repeat (4) @(negedge clk);
        chk("b2b_done_pulses", 32'(done_cnt[0] - d0), 32'd2);
        chk("b2b_cs_high_gap", 32'(last_gap[0]), 32'd1);
        chk("b2b_queue_empty", 32'(q_a.size()), 32'd0);

        // Fast-clock, no-turnaround instance.
        for (int t = 0; t < 4; t++) begin
            issue(1, 1'(t % 2), 7'($urandom), 8'($urandom), 8'($urandom));
            wait_done(1, 200);
        end

        // Idle: nothing moves without start.
        d0 = done_cnt[0];
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (cs_a !== 1'b1 || sclk_a !== 1'b0 || mosi_a !== 1'b0 || done_a !== 1'b0)
                chk("idle_pins", {28'd0, cs_a, sclk_a, mosi_a, done_a}, 32'h8);
        end
        chk("idle_no_done", 32'(done_cnt[0] - d0), 32'd0);

        // Randomized traffic with changing inputs after the latch cycle.
        for (int t = 0; t < 12; t++) begin
            issue(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
            wait_done(0, 400);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        chk("random_queue_empty", 32'(q_a.size()), 32'd0);

        // Asynchronous reset in the middle of a read frame.
        issue(0, 1'b1, 7'h4C, 8'h00, 8'h3C);
        k = 0;
        while (rises[0] < 9 && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) chk("reach_edge9_timeout", 32'd0, 32'd1);
        d0 = done_cnt[0];
        #2 reset = 1'b1;
        #1;
        chk("async_reset_cs", 32'(cs_a), 32'd1);
        chk("async_reset_sclk", 32'(sclk_a), 32'd0);
        chk("async_reset_busy", 32'(busy_a), 32'd0);
        chk("async_reset_rdata", 32'(rdata_a), 32'd0);
        chk("async_reset_mosi", 32'(mosi_a), 32'd0);
        q_a.delete();
        q_b.delete();
        model_rd[0] = 8'd0;
        model_rd[1] = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);

        // Recovery after reset.
        issue(0, 1'b0, 7'h7F, 8'hFF, 8'h00);
        wait_done(0, 400);
        issue(0, 1'b1, 7'h00, 8'h00, 8'h81);
        wait_done(0, 400);
        chk("recovery_rdata", 32'(rdata_a), 32'h81);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
